// File: rtl/clint_if.sv
`default_nettype none
// ============================================================================
// Module      : clint_if
// Description : Valid/ready request/response bus used to reach the CLINT
//               register window (one outstanding transaction).
// Revision    : 1.0 - initial release
// ============================================================================
interface clint_if;
   // Request channel
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;

   // Response channel
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   // Bus initiator (core data port or testbench)
   modport master (
      output req_valid,
      input  req_ready,
      output req_write,
      output req_addr,
      output req_wdata,
      output req_wstrb,
      input  resp_valid,
      output resp_ready,
      input  resp_rdata,
      input  resp_error
   );

   // Bus target (the CLINT)
   modport slave (
      input  req_valid,
      output req_ready,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      input  req_wstrb,
      output resp_valid,
      input  resp_ready,
      output resp_rdata,
      output resp_error
   );
endinterface
`default_nettype wire

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module      : clint
// Description : Core-local interruptor for a single hart. Holds the
//               memory-mapped mtime / mtimecmp / msip registers behind a
//               valid/ready slave bus and drives the level timer and software
//               interrupt lines into the machine-mode CSR unit.
// Revision    : 1.0 - initial release
// ============================================================================
module clint #(
   parameter int unsigned TICK_DIV  = 1,         // clk cycles per mtime increment (>=1)
   parameter logic [15:0] BASE_MASK = 16'hFFFF   // address bits taking part in decode
) (
   input  wire logic clk,
   input  wire logic reset,
   clint_if.slave    bus,
   output logic      timer_interrupt,
   output logic      software_interrupt
);

   // -------------------------------------------------------------------------
   // Register map (byte offsets inside the CLINT window)
   // -------------------------------------------------------------------------
   localparam logic [15:0] C_OFF_MSIP       = 16'h0000;
   localparam logic [15:0] C_OFF_MTIMECMP_L = 16'h4000;
   localparam logic [15:0] C_OFF_MTIMECMP_H = 16'h4004;
   localparam logic [15:0] C_OFF_MTIME_L    = 16'hBFF8;
   localparam logic [15:0] C_OFF_MTIME_H    = 16'hBFFC;

   localparam logic [63:0] C_MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF;

   // -------------------------------------------------------------------------
   // Architectural state
   // -------------------------------------------------------------------------
   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_msip;
   logic        r_timer_irq;
   logic        r_soft_irq;

   // Response holding registers; r_resp_valid doubles as the "busy" flag
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_error;

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic        w_tick;
   logic [15:0] w_addr;
   logic        w_aligned;
   logic        w_hit_msip;
   logic        w_hit_cmp_lo;
   logic        w_hit_cmp_hi;
   logic        w_hit_time_lo;
   logic        w_hit_time_hi;
   logic        w_mapped;
   logic        w_error;
   logic        w_accept;
   logic        w_wr;
   logic [31:0] w_rdata;
   logic [63:0] w_mtime_nxt;
   logic [63:0] w_mtimecmp_nxt;
   logic        w_msip_nxt;

   // Replace the strobed bytes of old_v with the matching bytes of new_v
   function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_v[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // mtime prescaler: a single tick strobe every TICK_DIV cycles
   // -------------------------------------------------------------------------
   generate
      if (TICK_DIV <= 1) begin : g_tick_every_cycle
         assign w_tick = 1'b1;
      end else begin : g_tick_prescaler
         localparam int unsigned C_PW = $clog2(TICK_DIV);
         localparam logic [C_PW-1:0] C_PS_LAST = C_PW'(TICK_DIV - 1);

         logic [C_PW-1:0] r_prescaler;

         // Count 0..TICK_DIV-1 and wrap; the wrap cycle is the tick
         always_ff @(posedge clk) begin
            if (reset) begin
               r_prescaler <= '0;
            end else if (r_prescaler == C_PS_LAST) begin
               r_prescaler <= '0;
            end else begin
               r_prescaler <= r_prescaler + 1'b1;
            end
         end

         assign w_tick = (r_prescaler == C_PS_LAST);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Address decode. Misaligned accesses never hit, so they report an error
   // and leave every register untouched.
   // -------------------------------------------------------------------------
   assign w_addr        = bus.req_addr & BASE_MASK;
   assign w_aligned     = (bus.req_addr[1:0] == 2'b00);
   assign w_hit_msip    = w_aligned && (w_addr == C_OFF_MSIP);
   assign w_hit_cmp_lo  = w_aligned && (w_addr == C_OFF_MTIMECMP_L);
   assign w_hit_cmp_hi  = w_aligned && (w_addr == C_OFF_MTIMECMP_H);
   assign w_hit_time_lo = w_aligned && (w_addr == C_OFF_MTIME_L);
   assign w_hit_time_hi = w_aligned && (w_addr == C_OFF_MTIME_H);
   assign w_mapped      = w_hit_msip | w_hit_cmp_lo | w_hit_cmp_hi
                        | w_hit_time_lo | w_hit_time_hi;
   assign w_error       = !w_mapped;

   // Only one transaction in flight: accept only while no response is held
   assign w_accept      = bus.req_valid && !r_resp_valid;
   assign w_wr          = w_accept && bus.req_write && w_mapped;

   // Read mux of the current (pre-update) register values
   always_comb begin
      w_rdata = 32'h0;
      if (w_hit_msip)    w_rdata = {31'h0, r_msip};
      if (w_hit_cmp_lo)  w_rdata = r_mtimecmp[31:0];
      if (w_hit_cmp_hi)  w_rdata = r_mtimecmp[63:32];
      if (w_hit_time_lo) w_rdata = r_mtime[31:0];
      if (w_hit_time_hi) w_rdata = r_mtime[63:32];
   end

   // Next mtime: free-running increment, overridden by a half write. A half
   // write freezes the other half at its pre-tick value, so no carry crosses.
   always_comb begin
      w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;
      if (w_wr && w_hit_time_lo) begin
         w_mtime_nxt = {r_mtime[63:32],
                        f_merge(r_mtime[31:0], bus.req_wdata, bus.req_wstrb)};
      end
      if (w_wr && w_hit_time_hi) begin
         w_mtime_nxt = {f_merge(r_mtime[63:32], bus.req_wdata, bus.req_wstrb),
                        r_mtime[31:0]};
      end
   end

   // Next mtimecmp and msip: byte-strobed writes only
   always_comb begin
      w_mtimecmp_nxt = r_mtimecmp;
      w_msip_nxt     = r_msip;
      if (w_wr && w_hit_cmp_lo) begin
         w_mtimecmp_nxt[31:0]  = f_merge(r_mtimecmp[31:0], bus.req_wdata, bus.req_wstrb);
      end
      if (w_wr && w_hit_cmp_hi) begin
         w_mtimecmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], bus.req_wdata, bus.req_wstrb);
      end
      if (w_wr && w_hit_msip && bus.req_wstrb[0]) begin
         w_msip_nxt = bus.req_wdata[0];
      end
   end

   // -------------------------------------------------------------------------
   // Timer/software state registers
   // -------------------------------------------------------------------------
   // Commit register updates; interrupts compare the registered values and
   // therefore follow any change one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mtime     <= 64'h0;
         r_mtimecmp  <= C_MTIMECMP_RST;
         r_msip      <= 1'b0;
         r_timer_irq <= 1'b0;
         r_soft_irq  <= 1'b0;
      end else begin
         r_mtime     <= w_mtime_nxt;
         r_mtimecmp  <= w_mtimecmp_nxt;
         r_msip      <= w_msip_nxt;
         r_timer_irq <= (r_mtime >= r_mtimecmp);
         r_soft_irq  <= r_msip;
      end
   end

   // -------------------------------------------------------------------------
   // Response channel
   // -------------------------------------------------------------------------
   // Capture the response on accept and hold it stable until it is consumed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_error <= 1'b0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_rdata <= (bus.req_write || w_error) ? 32'h0 : w_rdata;
         r_resp_error <= w_error;
      end else if (r_resp_valid && bus.resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   assign bus.req_ready      = !r_resp_valid;
   assign bus.resp_valid     = r_resp_valid;
   assign bus.resp_rdata     = r_resp_rdata;
   assign bus.resp_error     = r_resp_error;

   assign timer_interrupt    = r_timer_irq;
   assign software_interrupt = r_soft_irq;

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint
// Description : Directed self-checking bench for clint. Two instances share
//               the request stimulus: one with TICK_DIV=1, one with TICK_DIV=4;
//               sel4 picks whose response and interrupts are observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // Request stimulus (shared by both instances)
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_ready;
   logic        sel4;

   int n_checks = 0;
   int n_fail   = 0;
   int edges;

   clint_if bus1 ();
   clint_if bus4 ();

   logic irq_t1, irq_s1, irq_t4, irq_s4;

   assign bus1.req_valid  = req_valid;
   assign bus1.req_write  = req_write;
   assign bus1.req_addr   = req_addr;
   assign bus1.req_wdata  = req_wdata;
   assign bus1.req_wstrb  = req_wstrb;
   assign bus1.resp_ready = resp_ready;
   assign bus4.req_valid  = req_valid;
   assign bus4.req_write  = req_write;
   assign bus4.req_addr   = req_addr;
   assign bus4.req_wdata  = req_wdata;
   assign bus4.req_wstrb  = req_wstrb;
   assign bus4.resp_ready = resp_ready;

   clint #(.TICK_DIV(1), .BASE_MASK(16'hFFFF)) u_dut1 (
      .clk                (clk),
      .reset              (reset),
      .bus                (bus1.slave),
      .timer_interrupt    (irq_t1),
      .software_interrupt (irq_s1)
   );

   clint #(.TICK_DIV(4), .BASE_MASK(16'hFFFF)) u_dut4 (
      .clk                (clk),
      .reset              (reset),
      .bus                (bus4.slave),
      .timer_interrupt    (irq_t4),
      .software_interrupt (irq_s4)
   );

   // Observed signals of the selected instance
   logic        t_req_ready, t_resp_valid, t_resp_error, t_timer, t_soft;
   logic [31:0] t_resp_rdata;
   assign t_req_ready  = sel4 ? bus4.req_ready  : bus1.req_ready;
   assign t_resp_valid = sel4 ? bus4.resp_valid : bus1.resp_valid;
   assign t_resp_rdata = sel4 ? bus4.resp_rdata : bus1.resp_rdata;
   assign t_resp_error = sel4 ? bus4.resp_error : bus1.resp_error;
   assign t_timer      = sel4 ? irq_t4 : irq_t1;
   assign t_soft       = sel4 ? irq_s4 : irq_s1;

   // Clock edges since reset deassert (prescaler phase reference)
   always @(posedge clk) edges <= reset ? 0 : edges + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge
   task automatic req_issue(input logic wr, input logic [15:0] addr,
                            input logic [31:0] wd, input logic [3:0] st);
      int waited = 0;
      while (!t_req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!t_req_ready) check("req_ready_timeout", t_req_ready, 1'b1);
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_wstrb = st;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   // Collect the held response and consume it; returns at the next negedge
   task automatic resp_take(output logic [31:0] rd, output logic err);
      int waited = 0;
      while (!t_resp_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!t_resp_valid) check("resp_valid_timeout", t_resp_valid, 1'b1);
      rd  = t_resp_rdata;
      err = t_resp_error;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [31:0] rd, output logic err);
      req_issue(1'b0, addr, 32'h0, 4'h0);
      resp_take(rd, err);
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, output logic err);
      logic [31:0] rd;
      req_issue(1'b1, addr, wd, st);
      resp_take(rd, err);
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 16'h0;
      req_wdata  = 32'h0;
      req_wstrb  = 4'h0;
      resp_ready = 1'b1;
      sel4       = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", t_resp_valid, 1'b0);
      check("rst_req_ready",  t_req_ready,  1'b1);
      check("rst_resp_rdata", t_resp_rdata, 32'h0);
      check("rst_resp_error", t_resp_error, 1'b0);
      check("rst_timer",      t_timer,      1'b0);
      check("rst_soft",       t_soft,       1'b0);

      // ---------------- 1: mtime counts from reset ----------------
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus_read(16'hBFF8, rd, err);         // accepted on the 6th edge: 5 ticks done
      check("t1_mtime_lo", rd, 32'd5);
      check("t1_err", err, 1'b0);
      bus_read(16'hBFFC, rd, err);
      check("t1_mtime_hi", rd, 32'd0);
      bus_read(16'h4000, rd, err);
      check("t1_cmp_lo_rst", rd, 32'hFFFF_FFFF);

      // ---------------- 2: timer interrupt ----------------
      req_issue(1'b1, 16'h4000, 32'd20, 4'hF);   // edge A
      resp_take(rd, err);
      check("t2_write_rdata", rd, 32'h0);
      bus_write(16'hBFF8, 32'd0, 4'hF, err);     // edge A+2: mtime=0
      bus_write(16'h4004, 32'd0, 4'hF, err);     // edge A+4: mtimecmp=20
      check("t2_timer_low", t_timer, 1'b0);      // mtime=3
      repeat (17) @(posedge clk);
      @(negedge clk);                            // mtime just became 20
      check("t2_timer_at20", t_timer, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("t2_timer_rise", t_timer, 1'b1);
      req_issue(1'b1, 16'h4000, 32'd100, 4'hF);
      check("t2_timer_hold", t_timer, 1'b1);
      resp_take(rd, err);
      check("t2_timer_fall", t_timer, 1'b0);

      // ---------------- 3: software interrupt ----------------
      req_issue(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
      check("t3_soft_lag", t_soft, 1'b0);
      resp_take(rd, err);
      check("t3_soft_set", t_soft, 1'b1);
      bus_read(16'h0000, rd, err);
      check("t3_msip_read", rd, 32'd1);
      bus_write(16'h0000, 32'h0, 4'b1110, err);  // byte 0 not strobed
      bus_read(16'h0000, rd, err);
      check("t3_msip_nostrb", rd, 32'd1);
      bus_write(16'h0000, 32'h0, 4'b0001, err);
      check("t3_soft_clr", t_soft, 1'b0);

      // ---------------- strobed write and 64-bit wrap ----------------
      bus_write(16'h4004, 32'hAABB_CCDD, 4'b0101, err);
      bus_read(16'h4004, rd, err);
      check("strb_cmp_hi", rd, 32'h00BB_00DD);
      bus_write(16'hBFFC, 32'hFFFF_FFFF, 4'hF, err);  // edge G
      bus_write(16'hBFF8, 32'hFFFF_FFFE, 4'hF, err);  // edge G+2
      bus_read(16'hBFF8, rd, err);                    // edge G+4 sees all-ones
      check("wrap_lo_max", rd, 32'hFFFF_FFFF);
      bus_read(16'hBFFC, rd, err);                    // wrapped at G+4
      check("wrap_hi_zero", rd, 32'h0);

      // ---------------- 4: carry on tick, TICK_DIV=4 ----------------
      sel4 = 1'b1;
      for (int i = 0; i < 4 && (edges % 4) != 0; i++) @(negedge clk);
      bus_write(16'hBFFC, 32'h0, 4'hF, err);           // phase 1
      bus_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF, err);   // phase 3, tick at phase 4
      bus_read(16'hBFFC, rd, err);
      check("t4_hi_carry", rd, 32'd1);
      bus_read(16'hBFF8, rd, err);
      check("t4_lo_zero", rd, 32'd0);
      sel4 = 1'b0;

      // ---------------- 5: response back-pressure ----------------
      resp_ready = 1'b0;
      req_issue(1'b0, 16'h4000, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         check("t5_resp_valid", t_resp_valid, 1'b1);
         check("t5_rdata",      t_resp_rdata, 32'd100);
         check("t5_req_ready",  t_req_ready,  1'b0);
         req_write = 1'b1;
         req_addr  = 16'h0000;
         req_wdata = 32'h1;
         req_wstrb = 4'hF;
         req_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 1'b0;
      req_write = 1'b0;
      resp_take(rd, err);
      check("t5_rdata_final", rd, 32'd100);
      bus_read(16'h0000, rd, err);
      check("t5_msip_untouched", rd, 32'd0);

      // ---------------- 6: errors and reset mid-transaction ----------------
      bus_read(16'h1234, rd, err);
      check("t6_unmapped_err", err, 1'b1);
      check("t6_unmapped_rd", rd, 32'h0);
      bus_read(16'h4002, rd, err);
      check("t6_misalign_err", err, 1'b1);
      check("t6_misalign_rd", rd, 32'h0);
      bus_write(16'h4002, 32'h5, 4'hF, err);
      check("t6_wr_misalign_err", err, 1'b1);
      bus_read(16'h4000, rd, err);
      check("t6_cmp_unchanged", rd, 32'd100);
      check("t6_ok_err", err, 1'b0);

      resp_ready = 1'b0;
      req_issue(1'b0, 16'h4000, 32'h0, 4'h0);
      check("t6_pending", t_resp_valid, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_reset_drop", t_resp_valid, 1'b0);
      check("t6_reset_ready", t_req_ready, 1'b1);
      reset      = 1'b0;
      resp_ready = 1'b1;
      bus_read(16'h4000, rd, err);
      check("t6_cmp_after_rst", rd, 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
